// File: rtl/mario_obj_dma_pkg.sv
// Shared types and widths for the sprite DMA master (mario_obj_dma).
package mario_obj_dma_pkg;

    localparam int SRC_W = 16;
    localparam int DST_W = 10;
    localparam int CNT_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_WR,
        ST_REL
    } dma_state_t;

    function automatic logic xfer_len_ok(input int unsigned len);
        return (len >= 1) && (len <= 1024);
    endfunction

endpackage

// File: rtl/mario_busrq_hs.sv
// Z80 BUSRQ/BUSAK handshake: owns the bus request line, reports grant and
// a single-tick revoke pulse when the CPU takes the bus back mid-transfer.
module mario_busrq_hs (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cen,
    input  logic i_req_set,
    input  logic i_req_clr,
    input  logic i_busakn,
    output logic o_busrqn,
    output logic o_granted,
    output logic o_revoke
);

    logic r_busrqn;
    logic r_gnt_q;
    logic w_granted;

    assign w_granted = ~r_busrqn & ~i_busakn;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busrqn <= 1'b1;
            r_gnt_q  <= 1'b0;
        end else begin
            if (i_req_clr) begin
                r_busrqn <= 1'b1;
            end else if (i_req_set) begin
                r_busrqn <= 1'b0;
            end
            // grant history is tracked on ticks so a loss is seen on the tick the FSM acts on
            if (i_cen) begin
                r_gnt_q <= w_granted;
            end
        end
    end

    assign o_busrqn  = r_busrqn;
    assign o_granted = w_granted;
    assign o_revoke  = i_cen & r_gnt_q & ~w_granted;

endmodule

// File: rtl/mario_obj_dma.sv
// Sprite DMA master: copies XFER_LEN bytes from CPU RAM into object RAM on a trigger.
// Optional feature macro OBJ_DMA_VBLANK_SYNC_EN holds a pending transfer until vertical blank.
module mario_obj_dma
    import mario_obj_dma_pkg::*;
#(
    parameter logic [7:0]       SRC_LO   = 8'h00,
    parameter logic [CNT_W-1:0] XFER_LEN = 11'd384,
    parameter logic [DST_W-1:0] DST_BASE = 10'h000,
    parameter int unsigned      RD_WAIT  = 1
) (
    input  logic             I_CLK_48M,
    input  logic             I_RSTn,
    input  logic             I_CEN,
    input  logic             I_DMA_TRGn,
    input  logic [7:0]       I_DB,
    input  logic             I_BUSAKn,
    output logic             O_BUSRQn,
    output logic [SRC_W-1:0] O_MEM_A,
    output logic             O_MEM_RDn,
    input  logic [7:0]       I_MEM_D,
    input  logic             I_VBLK,
    output logic [DST_W-1:0] O_OBJ_DMA_A,
    output logic [7:0]       O_OBJ_DMA_D,
    output logic             O_OBJ_DMA_CE,
    output logic             O_BUSY
);

    if (!xfer_len_ok(32'(XFER_LEN)) || (RD_WAIT > 3)) begin : g_bad_cfg
        $error("mario_obj_dma: XFER_LEN must be 1..1024 and RD_WAIT 0..3");
    end

    localparam logic [1:0] WAIT_LAST = 2'(RD_WAIT);

    dma_state_t       r_state;
    logic             r_trg_d;
    logic             r_pending;
    logic             r_busy;
    logic             r_mem_rdn;
    logic [1:0]       r_wait;
    logic [SRC_W-1:0] r_src;
    logic [SRC_W-1:0] r_mem_a;
    logic [DST_W-1:0] r_dst;
    logic [DST_W-1:0] r_obj_a;
    logic [7:0]       r_obj_d;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_vblk_ok;
    logic w_start;
    logic w_granted;
    logic w_revoke;
    logic w_wr_tick;
    logic w_last;

`ifdef OBJ_DMA_VBLANK_SYNC_EN
    assign w_vblk_ok = I_VBLK;
`else
    logic w_unused_vblk;
    assign w_unused_vblk = I_VBLK;
    assign w_vblk_ok     = 1'b1;
`endif

    // the edge is accepted outside I_CEN so a same-cycle tick can already leave IDLE
    assign w_accept  = r_trg_d & ~I_DMA_TRGn & ~r_busy;
    assign w_start   = I_CEN & (r_state == ST_IDLE) & (r_pending | w_accept) & w_vblk_ok;
    assign w_wr_tick = I_CEN & (r_state == ST_WR) & ~w_revoke;
    assign w_last    = (r_cnt == CNT_W'(1));

    mario_busrq_hs u_hs (
        .i_clk     (I_CLK_48M),
        .i_rst_n   (I_RSTn),
        .i_cen     (I_CEN),
        .i_req_set (w_start),
        .i_req_clr (w_wr_tick & w_last),
        .i_busakn  (I_BUSAKn),
        .o_busrqn  (O_BUSRQn),
        .o_granted (w_granted),
        .o_revoke  (w_revoke)
    );

    always_ff @(posedge I_CLK_48M or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_state   <= ST_IDLE;
            r_trg_d   <= 1'b1;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_mem_rdn <= 1'b1;
            r_wait    <= 2'd0;
            r_src     <= '0;
            r_mem_a   <= '0;
            r_dst     <= '0;
            r_obj_a   <= '0;
            r_obj_d   <= '0;
            r_cnt     <= '0;
        end else begin
            r_trg_d <= I_DMA_TRGn;
            if (w_accept) begin
                r_pending <= 1'b1;
                r_busy    <= 1'b1;
                r_src     <= {I_DB, SRC_LO};
                r_dst     <= DST_BASE;
                r_cnt     <= XFER_LEN;
            end
            if (I_CEN) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_state   <= ST_REQ;
                            r_pending <= 1'b0;
                        end
                    end
                    ST_REQ: begin
                        if (w_granted) begin
                            r_state   <= ST_RD;
                            r_mem_a   <= r_src;
                            r_mem_rdn <= 1'b0;
                            r_wait    <= 2'd0;
                        end
                    end
                    ST_RD: begin
                        if (w_revoke) begin
                            r_state   <= ST_REQ;
                            r_mem_rdn <= 1'b1;
                        end else if (r_wait == WAIT_LAST) begin
                            r_state   <= ST_WR;
                            r_mem_rdn <= 1'b1;
                            r_obj_a   <= r_dst;
                            r_obj_d   <= I_MEM_D;
                        end else begin
                            r_wait <= r_wait + 2'd1;
                        end
                    end
                    ST_WR: begin
                        // a revoke here drops the write; the byte is fetched again after regrant
                        if (w_revoke) begin
                            r_state <= ST_REQ;
                        end else begin
                            r_src <= r_src + 16'd1;
                            r_dst <= r_dst + 10'd1;
                            r_cnt <= r_cnt - 11'd1;
                            if (w_last) begin
                                r_state <= ST_REL;
                            end else begin
                                r_state   <= ST_RD;
                                r_mem_a   <= r_src + 16'd1;
                                r_mem_rdn <= 1'b0;
                                r_wait    <= 2'd0;
                            end
                        end
                    end
                    ST_REL: begin
                        if (I_BUSAKn) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign O_MEM_A      = r_mem_a;
    assign O_MEM_RDn    = r_mem_rdn;
    assign O_OBJ_DMA_A  = r_obj_a;
    assign O_OBJ_DMA_D  = r_obj_d;
    // write strobe is the WR tick itself, so it is exactly one 48M cycle and only inside WR
    assign O_OBJ_DMA_CE = w_wr_tick;
    assign O_BUSY       = r_busy;

endmodule

// File: tb/tb_mario_obj_dma.sv
// Scoreboard bench for mario_obj_dma: a default instance plus a wrap-around instance.
module tb_mario_obj_dma;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cen, vblk, force_rev;
    logic       trgn1, trgn2, busakn1, busakn2;
    logic [7:0] db1, db2;

    logic        busrqn1, mem_rdn1, ce1, busy1;
    logic [15:0] mem_a1;
    logic [7:0]  mem_d1, obj_d1;
    logic [9:0]  obj_a1;
    logic        busrqn2, mem_rdn2, ce2, busy2;
    logic [15:0] mem_a2;
    logic [7:0]  mem_d2, obj_d2;
    logic [9:0]  obj_a2;

    int checks = 0;
    int failures = 0;
    int ce_cnt1 = 0;
    int ce_cnt2 = 0;
    int rd_ticks = 0;
    logic [17:0] sb1[$];
    logic [17:0] sb2[$];

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ {a[10:8], a[15:11]} ^ 8'hA5;
    endfunction

    assign mem_d1 = mem_f(mem_a1);
    assign mem_d2 = mem_f(mem_a2);

    mario_obj_dma dut1 (
        .I_CLK_48M(clk), .I_RSTn(rst_n), .I_CEN(cen), .I_DMA_TRGn(trgn1), .I_DB(db1),
        .I_BUSAKn(busakn1), .O_BUSRQn(busrqn1), .O_MEM_A(mem_a1), .O_MEM_RDn(mem_rdn1),
        .I_MEM_D(mem_d1), .I_VBLK(vblk), .O_OBJ_DMA_A(obj_a1), .O_OBJ_DMA_D(obj_d1),
        .O_OBJ_DMA_CE(ce1), .O_BUSY(busy1)
    );

    mario_obj_dma #(.SRC_LO(8'hF0), .XFER_LEN(11'd32), .DST_BASE(10'h3F0)) dut2 (
        .I_CLK_48M(clk), .I_RSTn(rst_n), .I_CEN(cen), .I_DMA_TRGn(trgn2), .I_DB(db2),
        .I_BUSAKn(busakn2), .O_BUSRQn(busrqn2), .O_MEM_A(mem_a2), .O_MEM_RDn(mem_rdn2),
        .I_MEM_D(mem_d2), .I_VBLK(vblk), .O_OBJ_DMA_A(obj_a2), .O_OBJ_DMA_D(obj_d2),
        .O_OBJ_DMA_CE(ce2), .O_BUSY(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] exp_entry(input logic [15:0] src0, input logic [9:0] dst0, input int i);
        logic [15:0] s;
        logic [9:0]  d;
        s = src0 + 16'(i);
        d = dst0 + 10'(i);
        return {d, mem_f(s)};
    endfunction

    // tick every third cycle; bus acknowledge follows bus request two ticks later
    initial begin : drv
        logic [1:0] bq_a, bq_b;
        logic       last;
        int         div;
        bq_a = 2'b11; bq_b = 2'b11; div = 0;
        cen = 1'b0; busakn1 = 1'b1; busakn2 = 1'b1;
        forever begin
            @(posedge clk);
            last = cen;
            #1;
            if (last) begin
                bq_a = {bq_a[0], busrqn1};
                bq_b = {bq_b[0], busrqn2};
            end
            div     = (div == 2) ? 0 : div + 1;
            cen     = (div == 0);
            busakn1 = force_rev | bq_a[1];
            busakn2 = bq_b[1];
        end
    end

    initial begin : mon
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (cen && !mem_rdn1) rd_ticks++;
            if (ce1) begin
                check("sb1_has_entry", 32'(sb1.size() > 0), 1);
                if (sb1.size() > 0) begin
                    e = sb1.pop_front();
                    check("obj_a1", 32'(obj_a1), 32'(e[17:8]));
                    check("obj_d1", 32'(obj_d1), 32'(e[7:0]));
                end
                check("rd_len", rd_ticks, 2);
                rd_ticks = 0;
                ce_cnt1++;
            end
            if (ce2) begin
                check("sb2_has_entry", 32'(sb2.size() > 0), 1);
                if (sb2.size() > 0) begin
                    e = sb2.pop_front();
                    check("obj_a2", 32'(obj_a2), 32'(e[17:8]));
                    check("obj_d2", 32'(obj_d2), 32'(e[7:0]));
                end
                ce_cnt2++;
            end
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (!cen);
    endtask

    task automatic trigger(input int which, input logic [7:0] page);
        @(negedge clk);
        if (which == 1) begin db1 = page; trgn1 = 1'b0; end
        else begin db2 = page; trgn2 = 1'b0; end
        @(negedge clk);
        @(negedge clk);
        trgn1 = 1'b1;
        trgn2 = 1'b1;
    endtask

    task automatic start1(input logic [7:0] page);
        ce_cnt1 = 0;
        for (int i = 0; i < 384; i++) sb1.push_back(exp_entry({page, 8'h00}, 10'h000, i));
        trigger(1, page);
        check("busy_rise", 32'(busy1), 1);
    endtask

    task automatic wait_done1(input string tag);
        int n = 0;
        while (busy1 && n < 8000) begin @(negedge clk); n++; end
        check({tag, "_busy_fall"}, 32'(busy1), 0);
        check({tag, "_busrqn_rel"}, 32'(busrqn1), 1);
        check({tag, "_sb_empty"}, sb1.size(), 0);
        check({tag, "_ce_total"}, ce_cnt1, 384);
        $display("xfer %s writes=%0d cycles=%0d", tag, ce_cnt1, n);
    endtask

    task automatic wait_ce1(input int target);
        int n = 0;
        while (ce_cnt1 < target && n < 8000) begin @(posedge clk); n++; end
        check("reach_byte", 32'(ce_cnt1 >= target), 1);
    endtask

    initial begin
        int n, ce_before;
        rst_n = 1'b0; trgn1 = 1'b1; trgn2 = 1'b1; db1 = 8'h00; db2 = 8'h00;
        vblk = 1'b1; force_rev = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busrqn", 32'(busrqn1), 1);
        check("rst_rdn", 32'(mem_rdn1), 1);
        check("rst_mem_a", 32'(mem_a1), 0);
        check("rst_obj_a", 32'(obj_a1), 0);
        check("rst_obj_d", 32'(obj_d1), 0);
        check("rst_ce", 32'(ce1), 0);
        check("rst_busy", 32'(busy1), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // basic transfer from page 69
        start1(8'h69);
        wait_done1("page69");

        // start condition with vertical blank low
        vblk = 1'b0;
        ce_cnt1 = 0;
        for (int i = 0; i < 384; i++) sb1.push_back(exp_entry(16'h5500, 10'h000, i));
        @(negedge clk);
        db1 = 8'h55; trgn1 = 1'b0;
        wait_tick();
        #2;
`ifdef OBJ_DMA_VBLANK_SYNC_EN
        check("vblk_hold_busrqn", 32'(busrqn1), 1);
        repeat (5) wait_tick();
        #2;
        check("vblk_hold_busrqn_late", 32'(busrqn1), 1);
        check("vblk_hold_ce", ce_cnt1, 0);
        vblk = 1'b1;
`else
        check("first_tick_busrqn", 32'(busrqn1), 0);
        vblk = 1'b1;
`endif
        @(negedge clk);
        trgn1 = 1'b1;
        wait_done1("page55_vblk");

        // source wrap FFFF->0000
        start1(8'hFF);
        wait_done1("pageFF_srcwrap");

        // second instance: source and destination both wrap
        ce_cnt2 = 0;
        for (int i = 0; i < 32; i++) sb2.push_back(exp_entry(16'hFFF0, 10'h3F0, i));
        trigger(2, 8'hFF);
        n = 0;
        while (busy2 && n < 2000) begin @(negedge clk); n++; end
        check("dut2_busy_fall", 32'(busy2), 0);
        check("dut2_sb_empty", sb2.size(), 0);
        check("dut2_ce_total", ce_cnt2, 32);
        $display("xfer dut2_wrap writes=%0d cycles=%0d", ce_cnt2, n);

        // bus taken back for 10 ticks at byte 100
        start1(8'h20);
        wait_ce1(100);
        force_rev = 1'b1;
        ce_before = ce_cnt1;
        repeat (2) wait_tick();
        #2;
        check("revoke_rdn", 32'(mem_rdn1), 1);
        check("revoke_busrqn", 32'(busrqn1), 0);
        repeat (8) wait_tick();
        check("revoke_no_ce", ce_cnt1, ce_before);
        force_rev = 1'b0;
        rd_ticks = 0;
        wait_done1("page20_revoke");

        // retrigger at byte 50 must be ignored
        start1(8'h42);
        wait_ce1(50);
        trigger(1, 8'h12);
        check("retrig_busy", 32'(busy1), 1);
        wait_done1("page42_retrig");

        // reset while writing byte 7
        start1(8'h30);
        wait_ce1(7);
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_rdn1 && n < 100);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ce", 32'(ce1), 0);
        check("rst_mid_busrqn", 32'(busrqn1), 1);
        check("rst_mid_busy", 32'(busy1), 0);
        check("rst_mid_rdn", 32'(mem_rdn1), 1);
        $display("xfer page30_reset aborted writes=%0d", ce_cnt1);
        sb1.delete();
        rd_ticks = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        rd_ticks = 0;
        start1(8'h31);
        wait_done1("page31_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
